// File: rtl/arm_mem_pkg.sv
// Shared types and constants for the instruction memory responder.
package arm_mem_pkg;

    // Width of the wait-state down-counter (covers 0..15 wait states).
    localparam int unsigned CNT_W = 4;

    // Instruction word returned alongside an address error.
    localparam logic [31:0] ERR_INSTR = 32'h0000_0000;

    // Responder control states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/inst_mem_array.sv
// Instruction storage: synchronous write from the load port, asynchronous read by word index.
module inst_mem_array #(
    parameter int unsigned DEPTH_WORDS = 64
) (
    input  logic                           clk,
    input  logic                           wr_en,
    input  logic [$clog2(DEPTH_WORDS)-1:0] wr_idx,
    input  logic [31:0]                    wr_data,
    input  logic [$clog2(DEPTH_WORDS)-1:0] rd_idx,
    output logic [31:0]                    rd_data
);

    logic [31:0] mem_q [DEPTH_WORDS];

    // Program image write; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/inst_mem_responder.sv
// Fetch-side responder: accepts one request, waits WAIT_STATES cycles, then
// holds the response until consumed. Flush abandons whatever is in flight.
module inst_mem_responder
    import arm_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [31:0] req_addr,
    output logic        req_ready,
    input  logic        flush,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_instr,
    output logic [31:0] resp_addr,
    output logic        resp_err,
    input  logic        ld_en,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_data
);

    localparam int unsigned     AW        = $clog2(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] WS_CNT   = CNT_W'(WAIT_STATES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam bit              ZERO_WAIT = (WAIT_STATES == 0);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       resp_instr_q, resp_instr_d;
    logic [31:0]       resp_addr_q, resp_addr_d;
    logic              resp_err_q, resp_err_d;

    logic              accept;
    logic              capture;
    logic [31:0]       cap_addr;
    logic              cap_err;
    logic [AW-1:0]     rd_idx;
    logic [31:0]       rd_data;
    logic              ld_we;
    logic              ld_unused;

    // True when the byte address maps onto an existing word (DEPTH_WORDS is a power of two).
    function automatic logic in_range(input logic [31:0] a);
        return (a[31:AW+2] == '0);
    endfunction

    // Capture source: the latched address in WAIT, the live request on a zero-wait accept.
    always_comb begin
        cap_addr = (state_q == ST_WAIT) ? addr_q : req_addr;
        cap_err  = (cap_addr[1:0] != 2'b00) || !in_range(cap_addr);
        rd_idx   = cap_addr[AW+1:2];
    end

    // Load port: byte-offset bits are ignored, out-of-range writes are dropped.
    assign ld_we     = ld_en && in_range(ld_addr);
    assign ld_unused = ^ld_addr[1:0];

    inst_mem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk    (clk),
        .wr_en  (ld_we),
        .wr_idx (ld_addr[AW+1:2]),
        .wr_data(ld_data),
        .rd_idx (rd_idx),
        .rd_data(rd_data)
    );

    // Next-state, handshake outputs and response capture; flush overrides everything.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        resp_instr_d = resp_instr_q;
        resp_addr_d  = resp_addr_q;
        resp_err_d   = resp_err_q;
        req_ready    = 1'b0;
        resp_valid   = 1'b0;
        accept       = 1'b0;
        capture      = 1'b0;

        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    req_ready = 1'b1;
                    accept    = req_valid;
                end
                ST_WAIT: begin
                    if (cnt_q <= CNT_ONE) begin
                        state_d = ST_RESP;
                        capture = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                ST_RESP: begin
                    resp_valid = 1'b1;
                    if (resp_ready) begin
                        req_ready = 1'b1;
                        accept    = req_valid;
                        if (!req_valid) begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            if (accept) begin
                addr_d = req_addr;
                cnt_d  = WS_CNT;
                if (ZERO_WAIT) begin
                    state_d = ST_RESP;
                    capture = 1'b1;
                end else begin
                    state_d = ST_WAIT;
                end
            end

            if (capture) begin
                resp_instr_d = cap_err ? ERR_INSTR : rd_data;
                resp_addr_d  = cap_addr;
                resp_err_d   = cap_err;
            end
        end
    end

    // Control and response registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            resp_instr_q <= '0;
            resp_addr_q  <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            resp_instr_q <= resp_instr_d;
            resp_addr_q  <= resp_addr_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign resp_instr = resp_instr_q;
    assign resp_addr  = resp_addr_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_inst_mem_responder.sv
// Bench for inst_mem_responder: instance 0 uses 2 wait states, instance 1 uses none.
module tb_inst_mem_responder;

    localparam int DEPTH = 64;
    localparam int WS0   = 2;
    localparam int WS1   = 0;

    logic clk = 1'b0;
    logic reset;
    logic ld_en;
    logic [31:0] ld_addr, ld_data;

    logic [1:0]       req_valid, flush, resp_ready;
    logic [1:0][31:0] req_addr;
    logic [1:0]       req_ready, resp_valid, resp_err;
    logic [1:0][31:0] resp_instr, resp_addr;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    inst_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS0)) u_ws2 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_addr(req_addr[0]), .req_ready(req_ready[0]),
        .flush(flush[0]), .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_instr(resp_instr[0]), .resp_addr(resp_addr[0]), .resp_err(resp_err[0]),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    inst_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS1)) u_ws0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_addr(req_addr[1]), .req_ready(req_ready[1]),
        .flush(flush[1]), .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_instr(resp_instr[1]), .resp_addr(resp_addr[1]), .resp_err(resp_err[1]),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s[%0d] at %0t: got %h, expected %h", name, inst, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Per instance: is a request held, how many cycles until its response shows,
    // and the response contents once it has been read.
    bit          m_has [2];
    int          m_rem [2];
    logic [31:0] m_req [2];
    logic [31:0] m_raddr [2];
    logic [31:0] m_instr [2];
    bit          m_err [2];
    logic [31:0] m_mem [DEPTH];

    function automatic int ws(input int i);
        return (i == 0) ? WS0 : WS1;
    endfunction

    function automatic bit addr_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a[31:2] >= DEPTH);
    endfunction

    function automatic bit exp_ready(input int i);
        return !flush[i] && (!m_has[i] || (m_rem[i] == 0 && resp_ready[i]));
    endfunction

    function automatic bit exp_valid(input int i);
        return !flush[i] && m_has[i] && (m_rem[i] == 0);
    endfunction

    function automatic void model_read(input int i, input logic [31:0] a);
        m_raddr[i] = a;
        m_err[i]   = addr_bad(a);
        m_instr[i] = m_err[i] ? 32'h0 : m_mem[int'(a[31:2])];
    endfunction

    initial begin
        for (int k = 0; k < DEPTH; k++) m_mem[k] = 32'h0;
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                m_has[i] = 0; m_rem[i] = 0; m_req[i] = 0;
                m_raddr[i] = 0; m_instr[i] = 0; m_err[i] = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                bit rdy;
                bit showing;
                rdy     = exp_ready(i);
                showing = m_has[i] && (m_rem[i] == 0);
                if (flush[i]) begin
                    m_has[i] = 0;
                end else begin
                    if (m_has[i] && m_rem[i] > 0) begin
                        m_rem[i]--;
                        if (m_rem[i] == 0) model_read(i, m_req[i]);
                    end
                    if (showing && resp_ready[i]) m_has[i] = 0;
                    if (rdy && req_valid[i]) begin
                        m_has[i] = 1;
                        m_req[i] = req_addr[i];
                        m_rem[i] = ws(i);
                        if (ws(i) == 0) model_read(i, req_addr[i]);
                    end
                end
            end
            if (ld_en && ld_addr[31:2] < DEPTH) m_mem[int'(ld_addr[31:2])] = ld_data;
        end
    end

    // Every-cycle comparison against the model, mid-cycle.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            for (int i = 0; i < 2; i++) begin
                chk("req_ready", i, 32'(req_ready[i]), 32'(exp_ready(i)));
                chk("resp_valid", i, 32'(resp_valid[i]), 32'(exp_valid(i)));
                if (exp_valid(i)) begin
                    chk("resp_instr", i, resp_instr[i], m_instr[i]);
                    chk("resp_addr", i, resp_addr[i], m_raddr[i]);
                    chk("resp_err", i, 32'(resp_err[i]), 32'(m_err[i]));
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_valid(input int i, output int n);
        n = 0;
        while (!resp_valid[i] && n < 20) begin
            cyc();
            n++;
        end
        chk("resp_valid_timeout", i, 32'(resp_valid[i]), 32'd1);
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        cyc();
        ld_en = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag, input int i);
        chk({tag, "_req_ready"}, i, 32'(req_ready[i]), 32'd1);
        chk({tag, "_resp_valid"}, i, 32'(resp_valid[i]), 32'd0);
        chk({tag, "_resp_instr"}, i, resp_instr[i], 32'h0);
        chk({tag, "_resp_addr"}, i, resp_addr[i], 32'h0);
        chk({tag, "_resp_err"}, i, 32'(resp_err[i]), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        reset = 1'b1;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        req_valid = '0; flush = '0; resp_ready = 2'b11;
        req_addr = '0;
        cyc(); cyc();
        #1;
        for (int i = 0; i < 2; i++) check_reset_vals("rst", i);
        reset = 1'b0;
        cyc();

        // Program image; word 3 via a byte address with junk low bits, word 63 at the top.
        for (int k = 0; k < 16; k++) begin
            if (k == 5)      load(32'h14, 32'hE3A0_1001);
            else if (k == 3) load(32'hE, 32'hA000_0003);
            else             load(32'(4 * k), 32'hA000_0000 + 32'(k));
        end
        load(32'hFC, 32'hCAFE_F00D);
        load(32'h100, 32'h5555_5555);

        // Preload and read, 2 wait states.
        req_valid[0] = 1'b1; req_addr[0] = 32'h14;
        #1 chk("idle_ready", 0, 32'(req_ready[0]), 32'd1);
        cyc();
        req_valid[0] = 1'b0;
        wait_valid(0, n);
        chk("read_latency", 0, 32'(n + 1), 32'd3);
        chk("read_instr", 0, resp_instr[0], 32'hE3A0_1001);
        chk("read_addr", 0, resp_addr[0], 32'h14);
        chk("read_err", 0, 32'(resp_err[0]), 32'd0);
        cyc();

        // Load to the word being captured in that same cycle returns the old word.
        req_valid[0] = 1'b1; req_addr[0] = 32'h18;
        cyc();
        req_valid[0] = 1'b0;
        cyc();
        ld_en = 1'b1; ld_addr = 32'h18; ld_data = 32'hDEAD_BEEF;
        cyc();
        ld_en = 1'b0;
        #1;
        chk("collide_valid", 0, 32'(resp_valid[0]), 32'd1);
        chk("collide_instr", 0, resp_instr[0], 32'hA000_0006);
        cyc();

        // Streaming with zero wait states; word 0 must survive the out-of-range load.
        req_valid[1] = 1'b1; req_addr[1] = 32'h0;
        cyc();
        for (int k = 0; k < 3; k++) begin
            req_addr[1] = 32'(4 * (k + 1));
            if (k == 2) req_valid[1] = 1'b0;
            #1;
            chk("stream_valid", 1, 32'(resp_valid[1]), 32'd1);
            chk("stream_addr", 1, resp_addr[1], 32'(4 * k));
            chk("stream_instr", 1, resp_instr[1], 32'hA000_0000 + 32'(k));
            chk("stream_ready", 1, 32'(req_ready[1]), 32'd1);
            cyc();
        end
        #1 chk("stream_done", 1, 32'(resp_valid[1]), 32'd0);

        // Last valid word on the zero-wait instance.
        req_valid[1] = 1'b1; req_addr[1] = 32'hFC;
        cyc();
        req_valid[1] = 1'b0;
        #1;
        chk("top_word_instr", 1, resp_instr[1], 32'hCAFE_F00D);
        chk("top_word_err", 1, 32'(resp_err[1]), 32'd0);
        cyc();

        // Stall hold for 4 cycles, then consume with a back-to-back request.
        resp_ready[0] = 1'b0;
        req_valid[0] = 1'b1; req_addr[0] = 32'h8;
        cyc();
        req_valid[0] = 1'b0;
        wait_valid(0, n);
        req_valid[0] = 1'b1; req_addr[0] = 32'hC;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("stall_ready", 0, 32'(req_ready[0]), 32'd0);
            chk("stall_valid", 0, 32'(resp_valid[0]), 32'd1);
            chk("stall_instr", 0, resp_instr[0], 32'hA000_0002);
            chk("stall_addr", 0, resp_addr[0], 32'h8);
            cyc();
        end
        resp_ready[0] = 1'b1;
        #1 chk("release_ready", 0, 32'(req_ready[0]), 32'd1);
        cyc();
        req_valid[0] = 1'b0;
        #1 chk("b2b_in_wait", 0, 32'(resp_valid[0]), 32'd0);
        wait_valid(0, n);
        chk("b2b_latency", 0, 32'(n + 1), 32'd3);
        chk("b2b_addr", 0, resp_addr[0], 32'hC);
        chk("b2b_instr", 0, resp_instr[0], 32'hA000_0003);
        cyc();

        // Address errors keep normal latency.
        for (int k = 0; k < 2; k++) begin
            req_valid[0] = 1'b1; req_addr[0] = (k == 0) ? 32'h6 : 32'h100;
            cyc();
            req_valid[0] = 1'b0;
            wait_valid(0, n);
            chk("err_latency", 0, 32'(n + 1), 32'd3);
            chk("err_flag", 0, 32'(resp_err[0]), 32'd1);
            chk("err_instr", 0, resp_instr[0], 32'h0);
            chk("err_addr", 0, resp_addr[0], (k == 0) ? 32'h6 : 32'h100);
            cyc();
        end

        // Flush in WAIT: request abandoned.
        req_valid[0] = 1'b1; req_addr[0] = 32'h10;
        cyc();
        req_valid[0] = 1'b0;
        flush[0] = 1'b1;
        #1;
        chk("flush_wait_ready", 0, 32'(req_ready[0]), 32'd0);
        chk("flush_wait_valid", 0, 32'(resp_valid[0]), 32'd0);
        cyc();
        flush[0] = 1'b0;
        #1 chk("after_flush_idle", 0, 32'(req_ready[0]), 32'd1);
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("flushed_no_resp", 0, 32'(resp_valid[0]), 32'd0);
        end

        // Flush in RESP with consume and a new request: nothing accepted.
        req_valid[0] = 1'b1; req_addr[0] = 32'h14;
        cyc();
        req_valid[0] = 1'b0;
        wait_valid(0, n);
        flush[0] = 1'b1; req_valid[0] = 1'b1; req_addr[0] = 32'h4;
        #1;
        chk("flush_resp_valid", 0, 32'(resp_valid[0]), 32'd0);
        chk("flush_resp_ready", 0, 32'(req_ready[0]), 32'd0);
        cyc();
        flush[0] = 1'b0; req_valid[0] = 1'b0;
        #1;
        chk("post_flush_valid", 0, 32'(resp_valid[0]), 32'd0);
        chk("post_flush_ready", 0, 32'(req_ready[0]), 32'd1);
        for (int k = 0; k < 4; k++) cyc();

        // Asynchronous reset in the middle of WAIT.
        req_valid[0] = 1'b1; req_addr[0] = 32'h8;
        cyc();
        req_valid[0] = 1'b0;
        #1 reset = 1'b1;
        #1 check_reset_vals("async_rst", 0);
        cyc();
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("rst_no_resp", 0, 32'(resp_valid[0]), 32'd0);
        end

        // Array contents survive reset.
        req_valid[0] = 1'b1; req_addr[0] = 32'h14;
        cyc();
        req_valid[0] = 1'b0;
        wait_valid(0, n);
        chk("survive_instr", 0, resp_instr[0], 32'hE3A0_1001);
        cyc(); cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/inst_mem_responder.md
# inst_mem_responder

Instruction memory responder that answers fetch requests from the instruction fetch stage with a valid/ready handshake and a configurable number of wait states. It sits between the fetch stage and the instruction storage array. It holds the current request until the response is consumed, aborts in-flight reads on branch flush, and flags misaligned or out-of-range addresses. A side load port lets the testbench or boot logic preload the program image.

## Interface
- `DEPTH_WORDS`, default 64: number of 32-bit instruction words; power of two, ≥ 4.
- `WAIT_STATES`, default 2: extra cycles between request acceptance and response; range 0..15.
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all control registers.
- `req_valid`  in  1  fetch stage presents a read request.
- `req_addr`  in  32  byte address of the instruction (PC).
- `req_ready`  out  1  responder can accept a request this cycle.
- `flush`  in  1  branch taken; abandon the in-flight request.
- `resp_valid`  out  1  `resp_instr`, `resp_addr` and `resp_err` are valid.
- `resp_ready`  in  1  fetch stage consumes the response; driven low while the pipeline is frozen.
- `resp_instr`  out  32  instruction word; 32'h0000_0000 when `resp_err`=1.
- `resp_addr`  out  32  byte address the response belongs to.
- `resp_err`  out  1  `req_addr[1:0]`≠0, or word index ≥ `DEPTH_WORDS`.
- `ld_en`  in  1  preload write strobe.
- `ld_addr`  in  32  preload byte address; bits [1:0] ignored.
- `ld_data`  in  32  preload word.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: `req_ready`=1. When `req_valid`=1 the request is accepted:
  - latch `req_addr`;
  - load the counter with `WAIT_STATES`;
  - go to WAIT, or directly to RESP when `WAIT_STATES`=0.
- WAIT: `req_ready`=0. The counter decrements each cycle. When it reaches 1, the next state is RESP. Array data and the error check are captured on that transition.
- RESP: `resp_valid`=1. Outputs hold stable until `resp_ready`=1.
  - On consumption, `req_ready`=1 in the same cycle. If `req_valid`=1 too, the new request is accepted: back-to-back, entering WAIT or RESP exactly as from IDLE.
  - Otherwise the FSM goes to IDLE.
- Error check: `resp_err`=1 if `addr[1:0]`≠0 or `addr[31:2]` ≥ `DEPTH_WORDS`. The array is not read and `resp_instr`=0. Errored responses follow the same timing as good ones.
- `flush`=1 in any state:
  - next state is IDLE, `resp_valid` is forced 0 in the same cycle, and any pending response is dropped;
  - `req_ready`=0 during the flush cycle, so no request is accepted in that cycle.
- Flush has priority over the response handshake and over a new request in the same cycle.
- Load port: when `ld_en`=1, `ld_data` is written to word `ld_addr[31:2]` at the clock edge, in any state.
  - Out-of-range load writes are ignored.
  - A write in the same cycle as the data capture returns the old word.
- Reset: the state register, counter and output registers are cleared. The array contents are not reset.

## Timing
- Reset values: `req_ready`=1 (IDLE), `resp_valid`=0, `resp_instr`=0, `resp_addr`=0, `resp_err`=0.
- Latency: `resp_valid` rises `WAIT_STATES`+1 cycles after the accepting edge.
- Throughput with `resp_ready` held at 1: one response every `WAIT_STATES`+1 cycles.
- `req_ready` and `resp_valid` are Moore outputs, except for the `resp_ready` pass-through in RESP and the `flush` override.
- If `reset` asserts mid-WAIT or mid-RESP: IDLE immediately (asynchronous), outputs at their reset values, and no response is ever produced for that request.

## Structure
- Package `arm_mem_pkg`:
  - FSM state enum (IDLE/WAIT/RESP);
  - `ERR_INSTR` = 32'h0;
  - counter width constant (4 bits).
- Sub-module `inst_mem_array`: `DEPTH_WORDS`×32 storage with synchronous write (load port) and asynchronous read by word index.
- Top level holds the FSM, the wait counter, the address latch and the error check.

## Test plan
- **Preload and read:** preload word 5 = 32'hE3A0_1001; `WAIT_STATES`=2; request addr 0x14 → `resp_valid` 3 cycles later, `resp_instr`=E3A0_1001, `resp_addr`=0x14, `resp_err`=0.
- **Streaming fetch:** `WAIT_STATES`=0 with `req_valid` and `resp_ready` held high, addrs 0x0, 0x4, 0x8 → one response per cycle, in order, back-to-back acceptance in RESP.
- **Stall hold:** hold `resp_ready`=0 for 4 cycles in RESP → outputs stable and `req_ready`=0 throughout; release → consumed, next request accepted the same cycle.
- **Address errors:** request addr 0x6 and addr 0x100 (`DEPTH_WORDS`=64) → `resp_err`=1 and `resp_instr`=0 for both, with normal latency.
- **Flush in WAIT:** `flush` during WAIT → IDLE next cycle and no `resp_valid` ever appears for that request. `flush`, `resp_ready` and `req_valid` all high in RESP → no acceptance and `resp_valid`=0 that cycle.
- **Async reset:** assert `reset` between clock edges mid-WAIT → outputs at reset values before the next edge. Preloaded array contents survive the reset.
